// File: rtl/mem_stage_hs_pkg.sv
// Shared definitions for the memory stage: FSM states, one-hot op bit positions, bus widths.
package mem_stage_hs_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_WAIT = 2'd2,
    MS_DONE = 2'd3
  } ms_state_e;

  localparam int BR_BUS_WD = 33;

  localparam int LD_LBU = 0;
  localparam int LD_LHU = 1;
  localparam int LD_LW  = 2;
  localparam int LD_LB  = 3;
  localparam int LD_LH  = 4;

  localparam int ST_SB = 0;
  localparam int ST_SH = 1;
  localparam int ST_SW = 2;

  // {br_target, br_op, C,S,V,Z, ld_op, st_op, mem_to_reg, reg_we, dest, st_data, alu_result, pc}
  function automatic int es_to_ms_bus_wd(int data_w, int br_op_w, int ld_op_w, int st_op_w);
    return 32 + br_op_w + 4 + ld_op_w + st_op_w + 7 + 2 * data_w + 32;
  endfunction

  function automatic int ms_to_ws_bus_wd(int data_w);
    return data_w + 39;
  endfunction

endpackage

// File: rtl/ms_load_align.sv
// Load data alignment: selects the addressed byte/half/word lane and extends it.
module ms_load_align
  import mem_stage_hs_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LD_OP_W = 5,
  localparam int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0]  rdata_i,
  input  logic [LANE_W-1:0]  lane_i,
  input  logic [LD_OP_W-1:0] ld_op_i,
  output logic [DATA_W-1:0]  result_o
);

  logic [DATA_W-1:0] shifted;

  assign shifted = rdata_i >> {lane_i, 3'b000};

  always_comb begin
    result_o = '0;
    if (ld_op_i[LD_LBU])     result_o = DATA_W'(shifted[7:0]);
    else if (ld_op_i[LD_LHU]) result_o = DATA_W'(shifted[15:0]);
    else if (ld_op_i[LD_LB])  result_o = DATA_W'($signed(shifted[7:0]));
    else if (ld_op_i[LD_LH])  result_o = DATA_W'($signed(shifted[15:0]));
    else if (ld_op_i[LD_LW])  result_o = DATA_W'($signed(shifted[31:0]));
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Pipeline memory stage with req/addr_ok/data_ok handshake and one-shot branch resolution.
// Optional MS_MISALIGN_EXC_EN: misaligned half/word raises ms_ex instead of forcing alignment.
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int BR_OP_W = 9,
  parameter int LD_OP_W = 5,
  parameter int ST_OP_W = 3,
  localparam int ES_W   = es_to_ms_bus_wd(DATA_W, BR_OP_W, LD_OP_W, ST_OP_W),
  localparam int MS_W   = ms_to_ws_bus_wd(DATA_W),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ws_allowin,
  output logic                 ms_allowin,
  input  logic                 es_to_ms_valid,
  input  logic [ES_W-1:0]      es_to_ms_bus,
  output logic                 ms_to_ws_valid,
  output logic [MS_W-1:0]      ms_to_ws_bus,
  output logic [BR_BUS_WD-1:0] br_bus,
  output logic                 data_req,
  output logic                 data_wr,
  output logic [STRB_W-1:0]    data_wstrb,
  output logic [31:0]          data_addr,
  output logic [DATA_W-1:0]    data_wdata,
  input  logic                 data_addr_ok,
  input  logic                 data_data_ok,
  input  logic [DATA_W-1:0]    data_rdata
);

  localparam int LANE_W  = $clog2(STRB_W);
  localparam int ALU_LSB = 32;
  localparam int ST_LSB  = ALU_LSB + 2 * DATA_W + 7;
  localparam int LD_LSB  = ST_LSB + ST_OP_W;

  ms_state_e         state_q;
  logic              ms_valid_q, br_fired_q, data_req_q;
  logic [ES_W-1:0]   bus_q;
  logic [DATA_W-1:0] rbuf_q;

  logic [31:0]        br_target, pc, addr_al;
  logic [BR_OP_W-1:0] br_op, br_cond;
  logic               flag_c, flag_s, flag_v, flag_z, mem_to_reg, reg_we;
  logic [LD_OP_W-1:0] ld_op, in_ld;
  logic [ST_OP_W-1:0] st_op, in_st;
  logic [4:0]         dest;
  logic [DATA_W-1:0]  st_data, alu_result, rdata_mux, ld_result, final_result, wdata;
  logic [STRB_W-1:0]  strb_base;
  logic [LANE_W-1:0]  lane;
  logic               ms_ready_go, accept, go_req, in_mem, in_exc, ms_ex, br_taken;

  assign {br_target, br_op, flag_c, flag_s, flag_v, flag_z, ld_op, st_op,
          mem_to_reg, reg_we, dest, st_data, alu_result, pc} = bus_q;

  assign in_ld = es_to_ms_bus[LD_LSB +: LD_OP_W];
  assign in_st = es_to_ms_bus[ST_LSB +: ST_OP_W];

  function automatic logic is_half(logic [LD_OP_W-1:0] ld, logic [ST_OP_W-1:0] st);
    return ld[LD_LH] | ld[LD_LHU] | st[ST_SH];
  endfunction

  function automatic logic is_word(logic [LD_OP_W-1:0] ld, logic [ST_OP_W-1:0] st);
    return ld[LD_LW] | st[ST_SW];
  endfunction

`ifdef MS_MISALIGN_EXC_EN
  function automatic logic misal(logic [LD_OP_W-1:0] ld, logic [ST_OP_W-1:0] st, logic [1:0] a);
    return (is_half(ld, st) && a[0]) || (is_word(ld, st) && (a != 2'b00));
  endfunction

  assign in_exc = misal(in_ld, in_st, es_to_ms_bus[ALU_LSB +: 2]);
  assign ms_ex  = ms_valid_q && misal(ld_op, st_op, alu_result[1:0]);
`else
  assign in_exc = 1'b0;
  assign ms_ex  = 1'b0;
`endif

  assign in_mem = (|in_ld) || (|in_st);

  // Memory entries always sit in REQ/WAIT/DONE, so IDLE with a valid entry means nothing to wait for.
  always_comb begin
    ms_ready_go = 1'b1;
    case (state_q)
      MS_REQ:  ms_ready_go = 1'b0;
      MS_WAIT: ms_ready_go = data_data_ok;
      default: ms_ready_go = 1'b1;
    endcase
  end

  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign accept         = es_to_ms_valid && ms_allowin;
  assign go_req         = accept && in_mem && !in_exc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MS_IDLE;
      ms_valid_q <= 1'b0;
      br_fired_q <= 1'b0;
      data_req_q <= 1'b0;
      bus_q      <= '0;
      rbuf_q     <= '0;
    end else begin
      if (accept) begin
        ms_valid_q <= 1'b1;
        bus_q      <= es_to_ms_bus;
      end else if (ms_to_ws_valid && ws_allowin) begin
        ms_valid_q <= 1'b0;
      end

      if (accept)        br_fired_q <= 1'b0;
      else if (br_taken) br_fired_q <= 1'b1;

      case (state_q)
        MS_IDLE: if (go_req) begin
          state_q    <= MS_REQ;
          data_req_q <= 1'b1;
        end
        MS_REQ: if (data_addr_ok) begin
          state_q    <= MS_WAIT;
          data_req_q <= 1'b0;
        end
        MS_WAIT: if (data_data_ok) begin
          if (ws_allowin) begin
            state_q    <= go_req ? MS_REQ : MS_IDLE;
            data_req_q <= go_req;
          end else begin
            state_q <= MS_DONE;
            rbuf_q  <= data_rdata;
          end
        end
        MS_DONE: if (ws_allowin) begin
          state_q    <= go_req ? MS_REQ : MS_IDLE;
          data_req_q <= go_req;
        end
        default: state_q <= MS_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_al = alu_result[31:0];
    if (is_word(ld_op, st_op))      addr_al[1:0] = 2'b00;
    else if (is_half(ld_op, st_op)) addr_al[0]   = 1'b0;
  end

  assign lane      = addr_al[LANE_W-1:0];
  assign data_addr = addr_al;
  assign data_req  = data_req_q;
  assign data_wr   = |st_op;

  always_comb begin
    strb_base = '0;
    wdata     = '0;
    if (st_op[ST_SB]) begin
      strb_base = STRB_W'(1);
      wdata     = {STRB_W{st_data[7:0]}};
    end else if (st_op[ST_SH]) begin
      strb_base = STRB_W'(3);
      wdata     = {(DATA_W/16){st_data[15:0]}};
    end else if (st_op[ST_SW]) begin
      strb_base = STRB_W'(15);
      wdata     = {(DATA_W/32){st_data[31:0]}};
    end
  end

  assign data_wstrb = strb_base << lane;
  assign data_wdata = wdata;

  assign rdata_mux = (state_q == MS_DONE) ? rbuf_q : data_rdata;

  ms_load_align #(
    .DATA_W  (DATA_W),
    .LD_OP_W (LD_OP_W)
  ) u_load_align (
    .rdata_i  (rdata_mux),
    .lane_i   (lane),
    .ld_op_i  (ld_op),
    .result_o (ld_result)
  );

  assign final_result = mem_to_reg ? ld_result : alu_result;
  assign ms_to_ws_bus = {ms_ex, reg_we & ~ms_ex, dest, final_result, pc};

  always_comb begin
    br_cond    = '1;
    br_cond[0] = flag_z;
    br_cond[1] = !flag_z;
    br_cond[2] = flag_s != flag_v;
    br_cond[3] = flag_z | (flag_s == flag_v);
    br_cond[4] = flag_c;
    br_cond[5] = flag_z | !flag_c;
  end

  assign br_taken = ms_valid_q && (|(br_op & br_cond)) && !br_fired_q;
  assign br_bus   = {br_taken, br_target};

endmodule

// File: doc/mem_stage_hs.md
MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameter DATA_W, default 32, data-bus width; only 32 and 64 are legal.
REQ-002 Parameter BR_OP_W, default 9, branch one-hot op width.
REQ-003 Parameter LD_OP_W, default 5, load one-hot op width (LBU, LHU, LW, LB, LH = bits 0..4).
REQ-004 Parameter ST_OP_W, default 3, store one-hot op width (SB, SH, SW = bits 0..2).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 ws_allowin  in  1  WB stage can accept.
REQ-009 ms_allowin  out  1  this stage can accept.
REQ-010 es_to_ms_valid  in  1  EX entry valid.
REQ-011 es_to_ms_bus  in  `ES_TO_MS_BUS_WD  br_target, br_op, C/S/V/Z flags, ld_op, st_op, mem_to_reg, reg_we, dest[4:0], store data, alu_result, pc.
REQ-012 ms_to_ws_valid  out  1  entry offered to WB.
REQ-013 ms_to_ws_bus  out  DATA_W+39  {ms_ex, reg_we, dest[4:0], final_result, pc[31:0]}.
REQ-014 br_bus  out  33  {br_taken, br_target[31:0]}.
REQ-015 data_req, data_wr  out  1 each  request strobe, write qualifier.
REQ-016 data_wstrb  out  DATA_W/8  byte-lane enables.
REQ-017 data_addr  out  32; data_wdata  out  DATA_W  (store data replicated across lanes).
REQ-018 data_addr_ok, data_data_ok  in  1 each; data_rdata  in  DATA_W.

Function
REQ-019 FSM states IDLE, REQ, WAIT, DONE; IDLE on reset.
REQ-020 Entry accepted when es_to_ms_valid && ms_allowin; ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
REQ-021 Accepted load/store: IDLE->REQ next cycle; non-memory entry stays IDLE with ms_ready_go=1.
REQ-022 REQ: data_req=1, address/strobe held stable; addr_ok -> WAIT.
REQ-023 WAIT: data_ok && ws_allowin -> retire same cycle, rdata passed combinationally; data_ok && !ws_allowin -> capture rdata into buffer, go DONE.
REQ-024 DONE: ms_ready_go=1 from buffer; leave on ws_allowin (IDLE or REQ if new memory entry accepted same cycle).
REQ-025 data_ok in IDLE or REQ is ignored; at most one request outstanding.
REQ-026 Byte lane = alu_result[log2(DATA_W/8)-1:0]; loaded byte/half right-justified, zero-extended (LBU/LHU) or sign-extended (LB/LH); LW on DATA_W=64 selects word by addr[2].
REQ-027 final_result = mem_to_reg ? load result : alu_result.
REQ-028 br_taken = ms_valid && condition && !br_fired; conditions: bit0 Z, bit1 !Z, bit2 S!=V, bit3 Z|(S==V), bit4 C, bit5 Z|!C, bits 6..8 unconditional.
REQ-029 br_fired set after first cycle br_taken=1, cleared on each new accepted entry; branch fires exactly one cycle per entry.

Reset
REQ-030 Reset mid-transaction: FSM IDLE, ms_valid=0, br_fired=0, data_req=0, buffer cleared; outputs ms_to_ws_valid=0, br_taken=0, ms_allowin=1.

Configuration
REQ-031 Macro MS_MISALIGN_EXC_EN: when defined, half at odd address or word not 4-aligned issues no data_req, goes ready same cycle, ms_ex=1, reg_we forced 0.
REQ-032 Without MS_MISALIGN_EXC_EN: ms_ex tied 0; misaligned address low bits forced to the access's natural alignment.

Structure
REQ-033 Shared header mycpu.h holds `ES_TO_MS_BUS_WD, `MS_TO_WS_BUS_WD, `BR_BUS_WD, bus field offsets and FSM state encodings.
REQ-034 One sub-module, ms_load_align: combinational lane select/extension, parametrised by DATA_W.

Verification
REQ-035 LB addr 0x1003, rdata 0x80FF_FF00, DATA_W=32 -> final_result 0xFFFF_FF80.
REQ-036 LW, addr_ok delayed 3 cycles, data_ok 2 later, ws_allowin=1 -> retire cycle of data_ok, data_req high exactly 4 cycles.
REQ-037 LHU addr 0x2002, data_ok with ws_allowin=0 for 5 cycles, rdata 0xBEEF_0000 -> DONE held, result 0x0000_BEEF after release, later rdata change ignored.
REQ-038 SH addr 0x10 data 0x1234 -> data_wr=1, wstrb 0b0011, wdata 0x1234_1234.
REQ-039 BEQ Z=1 with ws_allowin=0 for 3 cycles -> br_taken high one cycle only, target 0x1C000100.
REQ-040 Reset asserted in WAIT, then data_ok pulse -> no retire, FSM IDLE; with MS_MISALIGN_EXC_EN, LW addr 0x6 -> no data_req, ms_ex=1, reg_we=0.
